// File: rtl/quantizer_pkg.sv
// Shared types and constants for the threshold quantizer.
// Optional build macro QUANTIZER_NAN_DETECT_EN (see quantizer_pipe.sv).
package quantizer_pkg;

   typedef logic [31:0] float32_t;

   // Largest threshold table the 4-bit write address can reach
   localparam int THR_MAX = 16;

   localparam float32_t FP_EXP_MASK  = 32'h7F80_0000;
   localparam float32_t FP_FRAC_MASK = 32'h007F_FFFF;

   // Reset table, index 0 largest; entries past N_THR are never loaded
   localparam logic [THR_MAX-1:0][31:0] THR_INIT_DEFAULT = '{
      0: 32'h3F63_8E4C,   // +0.88889
      1: 32'h3F2A_AAE3,   // +0.66667
      2: 32'h3EE3_8DA4,   // +0.44444
      3: 32'h3E63_8DA4,   // +0.22222
      4: 32'h0000_0000,   //  0
      5: 32'hBE63_8DA4,   // -0.22222
      6: 32'hBEE3_8DA4,   // -0.44444
      7: 32'hBF2A_AAE3,   // -0.66667
      8: 32'hBF63_8E4C,   // -0.88889
      default: 32'h0000_0000
   };

   // Level width: enough bits to hold 0..n_thr
   function automatic int lw_f(input int n_thr);
      return $clog2(n_thr + 1);
   endfunction

   function automatic logic is_nan(input float32_t x);
      return ((x & FP_EXP_MASK) == FP_EXP_MASK) && ((x & FP_FRAC_MASK) != '0);
   endfunction

endpackage

// File: rtl/quantizer_if.sv
// Sample-in / level-out handshake bundle for quantizer_pipe.
// With QUANTIZER_NAN_DETECT_EN defined the bundle also carries out_nan.
interface quantizer_if #(
   parameter int N_CH = 4,
   parameter int LW   = 4
);

   logic                 in_valid;
   logic                 in_ready;
   logic [32*N_CH-1:0]   in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [LW*N_CH-1:0]   out_level;
`ifdef QUANTIZER_NAN_DETECT_EN
   logic [N_CH-1:0]      out_nan;

   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_level, out_nan);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_level, out_nan);
`else
   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_level);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_level);
`endif

endinterface

// File: rtl/fp32_gt.sv
// Combinational strict a > b on float32 with IEEE ordering:
// NaN compares false, +0 == -0, negatives ordered by inverted magnitude,
// denormals compared by bit pattern like any other finite value.
module fp32_gt
   import quantizer_pkg::*;
(
   input  float32_t a,
   input  float32_t b,
   output logic     gt
);

   // Sign/magnitude compare with NaN and signed-zero special cases
   always_comb begin
      gt = 1'b0;
      if (is_nan(a) || is_nan(b))
         gt = 1'b0;
      else if ((a[30:0] == '0) && (b[30:0] == '0))
         gt = 1'b0;
      else if (!a[31] && b[31])
         gt = 1'b1;
      else if (a[31] && !b[31])
         gt = 1'b0;
      else if (!a[31])
         gt = (a[30:0] > b[30:0]);
      else
         gt = (a[30:0] < b[30:0]);
   end

endmodule

// File: rtl/quantizer_pipe.sv
// Two-stage float32 threshold quantizer. S1 holds the per-lane
// "not greater than threshold" vector, S2 holds its population count.
// Build macro QUANTIZER_NAN_DETECT_EN: adds out_nan and forces NaN lanes
// to level 0; without it a NaN lane reports level N_THR.
module quantizer_pipe
   import quantizer_pkg::*;
#(
   parameter int                        N_CH     = 4,
   parameter int                        N_THR    = 9,
   parameter logic [THR_MAX-1:0][31:0]  THR_INIT = THR_INIT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        thr_we,
   input  logic [3:0]  thr_addr,
   input  float32_t    thr_data,
   quantizer_if.slave  bus
);

   localparam int LW = lw_f(N_THR);

   float32_t                      thr_q [N_THR];
   logic [N_CH-1:0][N_THR-1:0]    gt_w;
   logic [N_CH-1:0][N_THR-1:0]    s1_cmp;
   logic                          s1_valid;
   logic                          s2_valid;
   logic                          s1_load;
   logic                          s2_load;
   logic [LW*N_CH-1:0]            level_q;

   function automatic logic [LW-1:0] popcnt(input logic [N_THR-1:0] v);
      logic [LW-1:0] c;
      c = '0;
      for (int i = 0; i < N_THR; i++)
         c = c + LW'(v[i]);
      return c;
   endfunction

   // A stage may load when it is empty or its content moves on this cycle
   assign s2_load       = !s2_valid || bus.out_ready;
   assign s1_load       = !s1_valid || s2_load;
   assign bus.in_ready  = !rst && s1_load;
   assign bus.out_valid = s2_valid;
   assign bus.out_level = level_q;

   // Threshold register file; reset reload beats a coincident write
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_THR; i++)
            thr_q[i] <= THR_INIT[i];
      end else if (thr_we) begin
         for (int i = 0; i < N_THR; i++)
            if (thr_addr == 4'(i))
               thr_q[i] <= thr_data;
      end
   end

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      for (genvar t = 0; t < N_THR; t++) begin : g_thr
         fp32_gt u_gt (
            .a  (bus.in_data[32*ch +: 32]),
            .b  (thr_q[t]),
            .gt (gt_w[ch][t])
         );
      end
   end

`ifdef QUANTIZER_NAN_DETECT_EN
   logic [N_CH-1:0] nan_d;
   logic [N_CH-1:0] s1_nan;
   logic [N_CH-1:0] nan_q;

   always_comb begin
      nan_d = '0;
      for (int ch = 0; ch < N_CH; ch++)
         nan_d[ch] = is_nan(bus.in_data[32*ch +: 32]);
   end

   assign bus.out_nan = nan_q;
`endif

   // Stage 1: capture compare vectors against the thresholds in force now
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_cmp <= ~gt_w;
`ifdef QUANTIZER_NAN_DETECT_EN
            s1_nan <= nan_d;
`endif
         end
      end
   end

   // Stage 2: count per lane; output holds until the sink takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         level_q  <= '0;
`ifdef QUANTIZER_NAN_DETECT_EN
         nan_q    <= '0;
`endif
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            for (int ch = 0; ch < N_CH; ch++) begin
`ifdef QUANTIZER_NAN_DETECT_EN
               level_q[LW*ch +: LW] <= s1_nan[ch] ? '0 : popcnt(s1_cmp[ch]);
`else
               level_q[LW*ch +: LW] <= popcnt(s1_cmp[ch]);
`endif
            end
`ifdef QUANTIZER_NAN_DETECT_EN
            nan_q <= s1_nan;
`endif
         end
      end
   end

endmodule
